store_checkpoint_monitor: RTL and testbench
===========================================

Name: store_checkpoint_monitor

Overview:
- Synthesizable, parametrised pass/fail monitor for the pipelined RISC-V core's data-memory store bus (MemWrite/ALUResult/WriteData).
- Holds a programmable list of expected (address, data) store checkpoints, a fail sentinel and a cycle timeout.
- Generalises the single hard-wired "store 2047 to 0x508" completion check to N checkpoints, with ordered/unordered matching and a timeout.
- Sits beside the core in top; drives sticky done/pass/fail flags usable by the bench or an FPGA LED.

Parameters:
XLEN, 32, width of the address and data buses
N_CHK, 4, number of checkpoint slots (>=1)
TIMEOUT_CYCLES, 100000, run cycles before timeout fail; 0 disables the timeout
CNT_W, 32, width of cycle_count and store_count (saturating)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe, honoured only in IDLE
cfg_sel  in  2  0=checkpoint slot, 1=fail sentinel, 2=control
cfg_idx  in  max(1,$clog2(N_CHK))  slot index when cfg_sel=0
cfg_addr  in  XLEN  address field; when cfg_sel=2, bits[$clog2(N_CHK+1)-1:0]=active count
cfg_data  in  XLEN  data field; when cfg_sel=2, bit0=ordered mode, bit1=fail sentinel enable
start  in  1  arm the monitor (from IDLE, PASS or FAIL)
MemWrite  in  1  core store strobe
ALUResult  in  XLEN  store address
WriteData  in  XLEN  store data
done  out  1  sticky; PASS or FAIL reached
pass  out  1  sticky pass flag
fail  out  1  sticky fail flag
fail_code  out  2  0=none, 1=sentinel hit, 2=timeout, 3=ordered data mismatch
next_idx  out  max(1,$clog2(N_CHK))  ordered mode: index of the next expected slot
matched_mask  out  N_CHK  slots matched so far
cycle_count  out  CNT_W  cycles spent in RUN
store_count  out  CNT_W  MemWrite cycles seen in RUN

Behaviour:
- States: IDLE, RUN, PASS, FAIL.
- Reset (synchronous, any state, including mid-RUN): state=IDLE; all outputs 0; all slots, sentinel, count and mode registers 0.
- IDLE:
  - cfg_we writes the register selected by cfg_sel.
  - cfg_sel=3 is ignored.
  - A count above N_CHK is clamped to N_CHK on write.
- cfg_we outside IDLE is ignored.
- start in IDLE/PASS/FAIL:
  - Clears matched_mask, next_idx, counters, flags and fail_code.
  - Goes to RUN, or directly to PASS if count==0.
  - start in RUN is ignored.
- RUN, per posedge:
  - cycle_count increments and saturates at all-ones.
  - When MemWrite=1, store_count increments and saturates.
- RUN, store evaluation when MemWrite=1, in priority order:
  1. Sentinel enabled and address and data equal the sentinel: FAIL, code 1.
  2. Ordered mode:
     - Address==slot[next_idx].addr and data equal: set that mask bit and increment next_idx.
     - Address equal but data differ: FAIL, code 3.
     - Other addresses: ignored.
  3. Unordered mode:
     - Every unmatched active slot (index < count) whose address and data equal the store gets its mask bit set.
     - Several slots may match in the same cycle.
     - Non-matching stores are ignored.
- PASS is entered on the same edge at which the last active slot becomes matched.
- Timeout: TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 at an edge without a pass transition gives FAIL, code 2. A pass on that edge wins.
- Sentinel and last-slot match in the same cycle: FAIL, code 1.
- Latency: flags are registered. A store sampled at edge t shows pass/fail from edge t onward, i.e. visible in cycle t+1.
- PASS/FAIL are terminal and sticky until start or reset. Counters freeze; done=1.
- In PASS, pass=1 and fail=0; in FAIL, the reverse.
- Comparisons use full XLEN equality; the monitor does not check address alignment.

Test Plan:
- Single checkpoint (count=1, slot0=0x508/2047, unordered): stores 0x100/5, then 0x508/2047 -> pass=1 and done=1 the cycle after; store_count=2.
- Ordered, 3 slots (0x10/1, 0x14/2, 0x508/2047): stores 0x14/2 (ignored), 0x10/1, 0x14/2, 0x508/2047 -> next_idx 0→1→2, then pass; matched_mask=3'b111.
- Ordered mismatch: slot0=0x10/1; store 0x10/7 -> fail=1, fail_code=3, next_idx stays 0.
- Sentinel: sentinel=0x4D4/1236 enabled; store 0x4D4/1234 -> no effect; store 0x4D4/1236 -> fail, code 1. Sentinel plus last match in the same cycle -> code 1.
- Timeout: TIMEOUT_CYCLES=50, no matching store -> fail code 2 with cycle_count=50 exactly. TIMEOUT_CYCLES=0 -> no fail after 1000 cycles.
- Control: reset asserted mid-RUN -> IDLE with all outputs 0; cfg_we during RUN leaves slots unchanged; start after PASS re-arms with counters cleared; count=0 plus start -> PASS next cycle.

Source files
------------

// File: rtl/store_checkpoint_monitor_if.sv
// Store-bus, configuration and status bundle for store_checkpoint_monitor.
// The master side is the core/bench and the slave side is the monitor.
interface store_checkpoint_monitor_if #(
    parameter int XLEN  = 32,
    parameter int N_CHK = 4,
    parameter int CNT_W = 32
);
    localparam int IDX_W = (N_CHK > 1) ? $clog2(N_CHK) : 1;

    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [IDX_W-1:0] cfg_idx;
    logic [XLEN-1:0]  cfg_addr;
    logic [XLEN-1:0]  cfg_data;
    logic             start;
    logic             MemWrite;
    logic [XLEN-1:0]  ALUResult;
    logic [XLEN-1:0]  WriteData;
    logic             done;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_code;
    logic [IDX_W-1:0] next_idx;
    logic [N_CHK-1:0] matched_mask;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] store_count;

    modport master (
        output cfg_we, cfg_sel, cfg_idx, cfg_addr, cfg_data, start,
        output MemWrite, ALUResult, WriteData,
        input  done, pass, fail, fail_code, next_idx, matched_mask,
        input  cycle_count, store_count
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_idx, cfg_addr, cfg_data, start,
        input  MemWrite, ALUResult, WriteData,
        output done, pass, fail, fail_code, next_idx, matched_mask,
        output cycle_count, store_count
    );
endinterface

// File: rtl/store_checkpoint_monitor.sv
// Pass/fail monitor that watches core stores for a programmed list of (address, data) checkpoints.
// Flags are registered and become visible in the cycle after the deciding store; inputs are never stalled.
module store_checkpoint_monitor #(
    parameter int XLEN           = 32,
    parameter int N_CHK          = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic clk,
    input  logic reset,
    store_checkpoint_monitor_if.slave bus
);
    localparam int IDX_W = (N_CHK > 1) ? $clog2(N_CHK) : 1;
    localparam int CW    = $clog2(N_CHK + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(N_CHK);

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    state_t           state, stateNext;
    logic [XLEN-1:0]  slotAddr [N_CHK];
    logic [XLEN-1:0]  slotData [N_CHK];
    logic [XLEN-1:0]  sentAddr, sentData;
    logic [CW-1:0]    activeCnt;
    logic             orderedMode, sentEn;
    logic [N_CHK-1:0] matchedMask, maskNext, activeMask;
    logic [IDX_W-1:0] nextIdx, idxNext;
    logic [CNT_W-1:0] cycleCount, cycNext, storeCount, stNext;
    logic [1:0]       failCode, codeNext;
    logic             sentHit, ordAddrHit, ordDataHit;

    always_comb begin
        activeMask = '0;
        for (int i = 0; i < N_CHK; i++) begin
            activeMask[i] = (i < int'(activeCnt));
        end
    end

    assign sentHit    = bus.MemWrite && sentEn && (bus.ALUResult == sentAddr) && (bus.WriteData == sentData);
    assign ordAddrHit = bus.MemWrite && orderedMode && (bus.ALUResult == slotAddr[nextIdx]);
    assign ordDataHit = (bus.WriteData == slotData[nextIdx]);

    // Configuration registers only accept writes while the monitor is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CHK; i++) begin
                slotAddr[i] <= '0;
                slotData[i] <= '0;
            end
            sentAddr    <= '0;
            sentData    <= '0;
            activeCnt   <= '0;
            orderedMode <= 1'b0;
            sentEn      <= 1'b0;
        end else if (state == IDLE && bus.cfg_we) begin
            case (bus.cfg_sel)
                2'd0: begin
                    if (int'(bus.cfg_idx) < N_CHK) begin
                        slotAddr[bus.cfg_idx] <= bus.cfg_addr;
                        slotData[bus.cfg_idx] <= bus.cfg_data;
                    end
                end
                2'd1: begin
                    sentAddr <= bus.cfg_addr;
                    sentData <= bus.cfg_data;
                end
                2'd2: begin
                    activeCnt   <= (bus.cfg_addr[CW-1:0] > CNT_MAX) ? CNT_MAX : bus.cfg_addr[CW-1:0];
                    orderedMode <= bus.cfg_data[0];
                    sentEn      <= bus.cfg_data[1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            matchedMask <= '0;
            nextIdx     <= '0;
            cycleCount  <= '0;
            storeCount  <= '0;
            failCode    <= 2'd0;
        end else begin
            state       <= stateNext;
            matchedMask <= maskNext;
            nextIdx     <= idxNext;
            cycleCount  <= cycNext;
            storeCount  <= stNext;
            failCode    <= codeNext;
        end
    end

    always_comb begin
        stateNext = state;
        maskNext  = matchedMask;
        idxNext   = nextIdx;
        cycNext   = cycleCount;
        stNext    = storeCount;
        codeNext  = failCode;
        case (state)
            RUN: begin
                if (cycleCount != '1) cycNext = cycleCount + 1'b1;
                if (bus.MemWrite && storeCount != '1) stNext = storeCount + 1'b1;
                if (sentHit) begin
                    stateNext = FAIL;
                    codeNext  = 2'd1;
                end else begin
                    if (bus.MemWrite && orderedMode) begin
                        if (ordAddrHit && ordDataHit) begin
                            maskNext[nextIdx] = 1'b1;
                            idxNext           = nextIdx + 1'b1;
                        end
                    end else if (bus.MemWrite) begin
                        for (int i = 0; i < N_CHK; i++) begin
                            if (activeMask[i] && !matchedMask[i] &&
                                bus.ALUResult == slotAddr[i] && bus.WriteData == slotData[i])
                                maskNext[i] = 1'b1;
                        end
                    end
                    // A pass decided on this edge outranks a timeout on the same edge.
                    if ((maskNext & activeMask) == activeMask) begin
                        stateNext = PASS;
                    end else if (ordAddrHit && !ordDataHit) begin
                        stateNext = FAIL;
                        codeNext  = 2'd3;
                    end else if (TIMEOUT_CYCLES != 0 && cycleCount == TO_LAST) begin
                        stateNext = FAIL;
                        codeNext  = 2'd2;
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    maskNext  = '0;
                    idxNext   = '0;
                    cycNext   = '0;
                    stNext    = '0;
                    codeNext  = 2'd0;
                    stateNext = (activeCnt == '0) ? PASS : RUN;
                end
            end
        endcase
    end

    assign bus.done         = (state == PASS) || (state == FAIL);
    assign bus.pass         = (state == PASS);
    assign bus.fail         = (state == FAIL);
    assign bus.fail_code    = failCode;
    assign bus.next_idx     = nextIdx;
    assign bus.matched_mask = matchedMask;
    assign bus.cycle_count  = cycleCount;
    assign bus.store_count  = storeCount;
endmodule

// File: tb/tb_store_checkpoint_monitor.sv
// Scoreboard bench: stimulus queues expected status snapshots, a negedge monitor pops and compares them.
module tb_store_checkpoint_monitor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    store_checkpoint_monitor_if #(.XLEN(32), .N_CHK(4), .CNT_W(32)) bus1 ();
    store_checkpoint_monitor_if #(.XLEN(32), .N_CHK(4), .CNT_W(32)) bus2 ();

    store_checkpoint_monitor #(.XLEN(32), .N_CHK(4), .TIMEOUT_CYCLES(50), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    store_checkpoint_monitor #(.XLEN(32), .N_CHK(4), .TIMEOUT_CYCLES(0), .CNT_W(32)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2));

    typedef struct {
        int          due;
        bit          d2;
        string       name;
        logic [10:0] flags;
        bit          chkCnt;
        logic [31:0] cyc;
        logic [31:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   negCnt = 0;
    int   checks = 0;
    int   failures = 0;
    logic [10:0] actFlags;
    logic [31:0] actCyc, actSt;

    always @(negedge clk) begin
        negCnt++;
        while (sb.size() > 0 && sb[0].due <= negCnt) begin
            cur = sb.pop_front();
            if (cur.d2) begin
                actFlags = {bus2.done, bus2.pass, bus2.fail, bus2.fail_code, bus2.next_idx, bus2.matched_mask};
                actCyc   = bus2.cycle_count;
                actSt    = bus2.store_count;
            end else begin
                actFlags = {bus1.done, bus1.pass, bus1.fail, bus1.fail_code, bus1.next_idx, bus1.matched_mask};
                actCyc   = bus1.cycle_count;
                actSt    = bus1.store_count;
            end
            checks++;
            if (actFlags !== cur.flags || (cur.chkCnt && (actCyc !== cur.cyc || actSt !== cur.st))) begin
                failures++;
                $display("FAIL %s: got flags=%b cyc=%0d st=%0d, want flags=%b cyc=%0d st=%0d (counters checked=%0d)",
                         cur.name, actFlags, actCyc, actSt, cur.flags, cur.cyc, cur.st, cur.chkCnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags layout: done, pass, fail, fail_code[1:0], next_idx[1:0], matched_mask[3:0]
    task automatic expectStatus(input string nm, input bit d2, input logic dn, input logic ps, input logic fl,
                                input logic [1:0] code, input logic [1:0] idx, input logic [3:0] mask,
                                input bit chk, input logic [31:0] cyc, input logic [31:0] st);
        exp_t e;
        e.due    = negCnt + 1;
        e.d2     = d2;
        e.name   = nm;
        e.flags  = {dn, ps, fl, code, idx, mask};
        e.chkCnt = chk;
        e.cyc    = cyc;
        e.st     = st;
        sb.push_back(e);
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
        bus1.cfg_we = 1'b1; bus1.cfg_sel = sel; bus1.cfg_idx = idx; bus1.cfg_addr = a; bus1.cfg_data = d;
        step();
        bus1.cfg_we = 1'b0;
    endtask

    task automatic doStart();
        bus1.start = 1'b1;
        step();
        bus1.start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus1.MemWrite = 1'b1; bus1.ALUResult = a; bus1.WriteData = d;
        step();
        bus1.MemWrite = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus1.cfg_we = 0; bus1.cfg_sel = 0; bus1.cfg_idx = 0; bus1.cfg_addr = 0; bus1.cfg_data = 0;
        bus1.start = 0; bus1.MemWrite = 0; bus1.ALUResult = 0; bus1.WriteData = 0;
        bus2.cfg_we = 0; bus2.cfg_sel = 0; bus2.cfg_idx = 0; bus2.cfg_addr = 0; bus2.cfg_data = 0;
        bus2.start = 0; bus2.MemWrite = 0; bus2.ALUResult = 0; bus2.WriteData = 0;
        step();
        step();
        expectStatus("reset_state", 0, 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1, 0, 0);
        reset = 1'b0;

        // single checkpoint, unordered
        cfg(2'd0, 2'd0, 32'h508, 32'd2047);
        cfg(2'd2, 2'd0, 32'd1, 32'd0);
        doStart();
        store(32'h100, 32'd5);
        expectStatus("single_nomatch", 0, 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1, 1, 1);
        store(32'h508, 32'd2047);
        expectStatus("single_pass", 0, 1, 1, 0, 2'd0, 2'd0, 4'b0001, 1, 2, 2);
        repeat (3) step();
        expectStatus("single_sticky", 0, 1, 1, 0, 2'd0, 2'd0, 4'b0001, 1, 2, 2);
        doStart();
        expectStatus("rearm_cleared", 0, 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1, 0, 0);
        store(32'h508, 32'd2047);
        expectStatus("rearm_pass", 0, 1, 1, 0, 2'd0, 2'd0, 4'b0001, 1, 1, 1);

        // ordered, three slots
        doReset();
        cfg(2'd0, 2'd0, 32'h10, 32'd1);
        cfg(2'd0, 2'd1, 32'h14, 32'd2);
        cfg(2'd0, 2'd2, 32'h508, 32'd2047);
        cfg(2'd2, 2'd0, 32'd3, 32'd1);
        doStart();
        store(32'h14, 32'd2);
        expectStatus("ord_out_of_order", 0, 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1, 1, 1);
        store(32'h10, 32'd1);
        expectStatus("ord_slot0", 0, 0, 0, 0, 2'd0, 2'd1, 4'b0001, 1, 2, 2);
        store(32'h14, 32'd2);
        expectStatus("ord_slot1", 0, 0, 0, 0, 2'd0, 2'd2, 4'b0011, 1, 3, 3);
        store(32'h508, 32'd2047);
        expectStatus("ord_pass", 0, 1, 1, 0, 2'd0, 2'd3, 4'b0111, 1, 4, 4);

        // ordered data mismatch
        doReset();
        cfg(2'd0, 2'd0, 32'h10, 32'd1);
        cfg(2'd2, 2'd0, 32'd1, 32'd1);
        doStart();
        store(32'h10, 32'd7);
        expectStatus("ord_mismatch", 0, 1, 0, 1, 2'd3, 2'd0, 4'b0000, 1, 1, 1);

        // sentinel
        doReset();
        cfg(2'd0, 2'd0, 32'h508, 32'd2047);
        cfg(2'd1, 2'd0, 32'h4D4, 32'd1236);
        cfg(2'd2, 2'd0, 32'd1, 32'd2);
        doStart();
        store(32'h4D4, 32'd1234);
        expectStatus("sent_near_miss", 0, 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1, 1, 1);
        store(32'h4D4, 32'd1236);
        expectStatus("sent_hit", 0, 1, 0, 1, 2'd1, 2'd0, 4'b0000, 1, 2, 2);

        // sentinel and last match on the same store
        doReset();
        cfg(2'd0, 2'd0, 32'h4D4, 32'd1236);
        cfg(2'd1, 2'd0, 32'h4D4, 32'd1236);
        cfg(2'd2, 2'd0, 32'd1, 32'd2);
        doStart();
        store(32'h4D4, 32'd1236);
        expectStatus("sent_vs_match", 0, 1, 0, 1, 2'd1, 2'd0, 4'b0000, 1, 1, 1);

        // unordered: one store matches two identical slots
        doReset();
        cfg(2'd0, 2'd0, 32'h20, 32'd9);
        cfg(2'd0, 2'd1, 32'h20, 32'd9);
        cfg(2'd2, 2'd0, 32'd2, 32'd0);
        doStart();
        store(32'h20, 32'd9);
        expectStatus("unord_double", 0, 1, 1, 0, 2'd0, 2'd0, 4'b0011, 1, 1, 1);

        // timeout at 50 cycles
        doReset();
        cfg(2'd0, 2'd0, 32'h508, 32'd2047);
        cfg(2'd2, 2'd0, 32'd1, 32'd0);
        doStart();
        repeat (49) step();
        expectStatus("timeout_before", 0, 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1, 49, 0);
        step();
        expectStatus("timeout_fail", 0, 1, 0, 1, 2'd2, 2'd0, 4'b0000, 1, 50, 0);
        repeat (5) step();
        expectStatus("timeout_frozen", 0, 1, 0, 1, 2'd2, 2'd0, 4'b0000, 1, 50, 0);
        doStart();
        repeat (49) step();
        store(32'h508, 32'd2047);
        expectStatus("pass_beats_timeout", 0, 1, 1, 0, 2'd0, 2'd0, 4'b0001, 1, 50, 1);

        // cfg_we ignored during RUN
        doReset();
        cfg(2'd0, 2'd0, 32'h508, 32'd2047);
        cfg(2'd2, 2'd0, 32'd1, 32'd0);
        doStart();
        cfg(2'd0, 2'd0, 32'h600, 32'd1);
        store(32'h508, 32'd2047);
        expectStatus("cfg_locked_in_run", 0, 1, 1, 0, 2'd0, 2'd0, 4'b0001, 1, 2, 1);

        // reset mid-RUN, then count==0 start
        doReset();
        cfg(2'd0, 2'd0, 32'h508, 32'd2047);
        cfg(2'd2, 2'd0, 32'd1, 32'd0);
        doStart();
        store(32'h100, 32'd5);
        expectStatus("pre_reset_run", 0, 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1, 1, 1);
        doReset();
        expectStatus("mid_run_reset", 0, 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1, 0, 0);
        doStart();
        expectStatus("count0_pass", 0, 1, 1, 0, 2'd0, 2'd0, 4'b0000, 1, 0, 0);

        // timeout disabled
        doReset();
        bus2.cfg_we = 1; bus2.cfg_sel = 2'd0; bus2.cfg_idx = 0; bus2.cfg_addr = 32'h508; bus2.cfg_data = 32'd2047;
        step();
        bus2.cfg_sel = 2'd2; bus2.cfg_addr = 32'd1; bus2.cfg_data = 32'd0;
        step();
        bus2.cfg_we = 0;
        bus2.start = 1;
        step();
        bus2.start = 0;
        repeat (1000) step();
        expectStatus("no_timeout_1000", 1, 0, 0, 0, 2'd0, 2'd0, 4'b0000, 1, 1000, 0);

        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
